// File: rtl/sb_axi_rd_arb.sv
// sb_axi_rd_arb: two-to-one AXI4 read-channel arbiter.
// AR requests from two upstream ports are arbitrated into one registered
// downstream AR slot.  The upstream port index is prepended to the
// downstream ARID, and R beats are steered back combinationally by that bit.
// Per-port outstanding-burst counters throttle each port.  The sticky err
// output flags R completions for a port with nothing outstanding.
// Optional build macro: SB_AXI_RD_ARB_FIXED_PRIO_EN selects fixed priority
// (port 0 wins ties) instead of the default round-robin.
module sb_axi_rd_arb #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 16,
   parameter int ID_WIDTH        = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   // upstream port 0 AR
   input  logic [ID_WIDTH-1:0]   s0_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
   input  logic [7:0]            s0_axi_arlen,
   input  logic [2:0]            s0_axi_arsize,
   input  logic [1:0]            s0_axi_arburst,
   input  logic                  s0_axi_arlock,
   input  logic [3:0]            s0_axi_arcache,
   input  logic [2:0]            s0_axi_arprot,
   input  logic                  s0_axi_arvalid,
   output logic                  s0_axi_arready,
   // upstream port 0 R
   output logic [ID_WIDTH-1:0]   s0_axi_rid,
   output logic [DATA_WIDTH-1:0] s0_axi_rdata,
   output logic [1:0]            s0_axi_rresp,
   output logic                  s0_axi_rlast,
   output logic                  s0_axi_rvalid,
   input  logic                  s0_axi_rready,
   // upstream port 1 AR
   input  logic [ID_WIDTH-1:0]   s1_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
   input  logic [7:0]            s1_axi_arlen,
   input  logic [2:0]            s1_axi_arsize,
   input  logic [1:0]            s1_axi_arburst,
   input  logic                  s1_axi_arlock,
   input  logic [3:0]            s1_axi_arcache,
   input  logic [2:0]            s1_axi_arprot,
   input  logic                  s1_axi_arvalid,
   output logic                  s1_axi_arready,
   // upstream port 1 R
   output logic [ID_WIDTH-1:0]   s1_axi_rid,
   output logic [DATA_WIDTH-1:0] s1_axi_rdata,
   output logic [1:0]            s1_axi_rresp,
   output logic                  s1_axi_rlast,
   output logic                  s1_axi_rvalid,
   input  logic                  s1_axi_rready,
   // downstream AR
   output logic [ID_WIDTH:0]     m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   // downstream R
   input  logic [ID_WIDTH:0]     m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   // sticky protocol error
   output logic                  err
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

   // AR slot registers and their next-state values
   logic                  arvalid_q, arvalid_d;
   logic [ID_WIDTH:0]     arid_q, arid_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]            arlen_q, arlen_d;
   logic [2:0]            arsize_q, arsize_d;
   logic [1:0]            arburst_q, arburst_d;
   logic                  arlock_q, arlock_d;
   logic [3:0]            arcache_q, arcache_d;
   logic [2:0]            arprot_q, arprot_d;

   // outstanding counters (index = port) and sticky error
   logic [1:0][CW-1:0]    cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic                  slot_open_s;
   logic [1:0]            elig_s;
   logic                  gnt_vld_s;
   logic                  gnt_port_s;
   logic                  r_port_s;
   logic [1:0]            inc_s;
   logic [1:0]            cmp_s;

`ifndef SB_AXI_RD_ARB_FIXED_PRIO_EN
   logic                  last_grant_q;
`endif

   assign slot_open_s = ~arvalid_q | m_axi_arready;
   assign elig_s[0]   = s0_axi_arvalid & (cnt_q[0] < CNT_MAX);
   assign elig_s[1]   = s1_axi_arvalid & (cnt_q[1] < CNT_MAX);

   // Grant selection among eligible ports; ties go round-robin or to port 0
   always_comb begin
      gnt_vld_s  = 1'b0;
      gnt_port_s = 1'b0;
      case (elig_s)
         2'b01: begin
            gnt_vld_s  = 1'b1;
            gnt_port_s = 1'b0;
         end
         2'b10: begin
            gnt_vld_s  = 1'b1;
            gnt_port_s = 1'b1;
         end
         2'b11: begin
            gnt_vld_s  = 1'b1;
`ifdef SB_AXI_RD_ARB_FIXED_PRIO_EN
            gnt_port_s = 1'b0;
`else
            gnt_port_s = ~last_grant_q;
`endif
         end
         default: begin
            gnt_vld_s  = 1'b0;
            gnt_port_s = 1'b0;
         end
      endcase
   end

   assign s0_axi_arready = slot_open_s & gnt_vld_s & ~gnt_port_s & ~rst;
   assign s1_axi_arready = slot_open_s & gnt_vld_s &  gnt_port_s & ~rst;

   // R steering: the top ID bit names the upstream port; payload is broadcast
   assign r_port_s      = m_axi_rid[ID_WIDTH];
   assign s0_axi_rvalid = m_axi_rvalid & ~r_port_s;
   assign s1_axi_rvalid = m_axi_rvalid &  r_port_s;
   assign m_axi_rready  = r_port_s ? s1_axi_rready : s0_axi_rready;
   assign s0_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
   assign s1_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
   assign s0_axi_rdata  = m_axi_rdata;
   assign s1_axi_rdata  = m_axi_rdata;
   assign s0_axi_rresp  = m_axi_rresp;
   assign s1_axi_rresp  = m_axi_rresp;
   assign s0_axi_rlast  = m_axi_rlast;
   assign s1_axi_rlast  = m_axi_rlast;

   // per-port grant and burst-completion strobes
   assign inc_s = {gnt_port_s, ~gnt_port_s} & {2{slot_open_s & gnt_vld_s}};
   assign cmp_s = {r_port_s, ~r_port_s} & {2{m_axi_rvalid & m_axi_rready & m_axi_rlast}};

   // Next AR slot: load the winner when open, drain when open with no winner
   always_comb begin
      arvalid_d = arvalid_q;
      arid_d    = arid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      arburst_d = arburst_q;
      arlock_d  = arlock_q;
      arcache_d = arcache_q;
      arprot_d  = arprot_q;
      if (slot_open_s) begin
         if (gnt_vld_s) begin
            arvalid_d = 1'b1;
            if (gnt_port_s) begin
               arid_d    = {1'b1, s1_axi_arid};
               araddr_d  = s1_axi_araddr;
               arlen_d   = s1_axi_arlen;
               arsize_d  = s1_axi_arsize;
               arburst_d = s1_axi_arburst;
               arlock_d  = s1_axi_arlock;
               arcache_d = s1_axi_arcache;
               arprot_d  = s1_axi_arprot;
            end else begin
               arid_d    = {1'b0, s0_axi_arid};
               araddr_d  = s0_axi_araddr;
               arlen_d   = s0_axi_arlen;
               arsize_d  = s0_axi_arsize;
               arburst_d = s0_axi_arburst;
               arlock_d  = s0_axi_arlock;
               arcache_d = s0_axi_arcache;
               arprot_d  = s0_axi_arprot;
            end
         end else begin
            arvalid_d = 1'b0;
         end
      end else begin
         arvalid_d = arvalid_q;
      end
   end

   // Outstanding counters: grant increments, completion decrements, both cancel;
   // a completion with nothing outstanding saturates at zero and raises err
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      for (int p = 0; p < 2; p++) begin
         if (cmp_s[p] && (cnt_q[p] == CNT_ZERO)) begin
            err_d = 1'b1;
         end else begin
            err_d = err_d;
         end
         if (inc_s[p] && cmp_s[p]) begin
            cnt_d[p] = cnt_q[p];
         end else if (inc_s[p]) begin
            cnt_d[p] = cnt_q[p] + CNT_ONE;
         end else if (cmp_s[p] && (cnt_q[p] != CNT_ZERO)) begin
            cnt_d[p] = cnt_q[p] - CNT_ONE;
         end else begin
            cnt_d[p] = cnt_q[p];
         end
      end
   end

   // State registers: AR slot, counters and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arvalid_q <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= 8'd0;
         arsize_q  <= 3'd0;
         arburst_q <= 2'd0;
         arlock_q  <= 1'b0;
         arcache_q <= 4'd0;
         arprot_q  <= 3'd0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         arvalid_q <= arvalid_d;
         arid_q    <= arid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         arlock_q  <= arlock_d;
         arcache_q <= arcache_d;
         arprot_q  <= arprot_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

`ifndef SB_AXI_RD_ARB_FIXED_PRIO_EN
   // Round-robin memory: remember the most recent winner; port 0 wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else if (slot_open_s && gnt_vld_s) begin
         last_grant_q <= gnt_port_s;
      end else begin
         last_grant_q <= last_grant_q;
      end
   end
`endif

   assign m_axi_arvalid = arvalid_q;
   assign m_axi_arid    = arid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = arsize_q;
   assign m_axi_arburst = arburst_q;
   assign m_axi_arlock  = arlock_q;
   assign m_axi_arcache = arcache_q;
   assign m_axi_arprot  = arprot_q;
   assign err           = err_q;

endmodule

// File: tb/tb_sb_axi_rd_arb.sv
// Testbench for sb_axi_rd_arb: table-driven contention vectors, directed
// corner-case sequences and a randomized run against a transaction-level model.
module tb_sb_axi_rd_arb;

   localparam int MAXO = 4;

   typedef struct packed {
      logic [7:0]  id;
      logic [15:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
   } ar_t;

   typedef struct {
      bit v0;
      bit v1;
      bit mrdy;
      bit e0;
      bit e1;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   ar_t  ar0, ar1;
   logic v0, v1, rdy0, rdy1;
   logic [7:0]  s0_rid, s1_rid;
   logic [31:0] s0_rdata, s1_rdata;
   logic [1:0]  s0_rresp, s1_rresp;
   logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, rr0, rr1;
   logic [8:0]  m_arid;
   logic [15:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic        m_arlock;
   logic [3:0]  m_arcache;
   logic [2:0]  m_arprot;
   logic        m_arvalid, m_arready;
   logic [8:0]  m_rid;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast, m_rvalid, m_rready, err;

   int checks = 0;
   int errors = 0;

   // reference model state (transaction level)
   int        mc[2];
   int        mlg;
   bit        mv;
   bit        merr;
   logic [45:0] mslot;

   logic smp_rdy0, smp_rdy1, smp_mrready;

   always #5 clk = ~clk;

   sb_axi_rd_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst(rst),
      .s0_axi_arid(ar0.id), .s0_axi_araddr(ar0.addr), .s0_axi_arlen(ar0.len),
      .s0_axi_arsize(ar0.size), .s0_axi_arburst(ar0.burst), .s0_axi_arlock(ar0.lock),
      .s0_axi_arcache(ar0.cache), .s0_axi_arprot(ar0.prot),
      .s0_axi_arvalid(v0), .s0_axi_arready(rdy0),
      .s0_axi_rid(s0_rid), .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp),
      .s0_axi_rlast(s0_rlast), .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(rr0),
      .s1_axi_arid(ar1.id), .s1_axi_araddr(ar1.addr), .s1_axi_arlen(ar1.len),
      .s1_axi_arsize(ar1.size), .s1_axi_arburst(ar1.burst), .s1_axi_arlock(ar1.lock),
      .s1_axi_arcache(ar1.cache), .s1_axi_arprot(ar1.prot),
      .s1_axi_arvalid(v1), .s1_axi_arready(rdy1),
      .s1_axi_rid(s1_rid), .s1_axi_rdata(s1_rdata), .s1_axi_rresp(s1_rresp),
      .s1_axi_rlast(s1_rlast), .s1_axi_rvalid(s1_rvalid), .s1_axi_rready(rr1),
      .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
      .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
      .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
      .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
      .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
      .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
      .err(err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic ar_t rand_ar();
      ar_t a;
      a = ar_t'({$urandom(), $urandom()});
      return a;
   endfunction

   // One clock cycle: check combinational outputs, advance model, check registers.
   task automatic step();
      bit e0, e1, open, rp, pready, cmp;
      int win;
      @(negedge clk);
      open = !mv || m_arready;
      e0 = v0 && (mc[0] < MAXO);
      e1 = v1 && (mc[1] < MAXO);
      win = -1;
      if (e0 && e1) begin
`ifdef SB_AXI_RD_ARB_FIXED_PRIO_EN
         win = 0;
`else
         win = 1 - mlg;
`endif
      end else if (e0) win = 0;
      else if (e1) win = 1;
      rp = m_rid[8];
      pready = rp ? rr1 : rr0;
      chk("arready0", rdy0, !rst && open && (win == 0));
      chk("arready1", rdy1, !rst && open && (win == 1));
      chk("rvalid0", s0_rvalid, m_rvalid && !rp);
      chk("rvalid1", s1_rvalid, m_rvalid && rp);
      chk("m_rready", m_rready, pready);
      chk("rid0", s0_rid, m_rid[7:0]);
      chk("rid1", s1_rid, m_rid[7:0]);
      chk("rdata", {s0_rdata, s1_rdata}, {m_rdata, m_rdata});
      chk("rresp_last", {s0_rresp, s0_rlast, s1_rresp, s1_rlast}, {m_rresp, m_rlast, m_rresp, m_rlast});
      smp_rdy0 = rdy0;
      smp_rdy1 = rdy1;
      smp_mrready = m_rready;
      cmp = m_rvalid && pready && m_rlast;
      @(posedge clk);
      if (rst) begin
         mc[0] = 0; mc[1] = 0; mlg = 1; mv = 0; merr = 0; mslot = '0;
      end else begin
         if (cmp && mc[rp] == 0) merr = 1;
         if (open && win >= 0) begin
            mslot = {win[0], (win == 0) ? ar0 : ar1};
            mv = 1;
            mlg = win;
         end else if (open) begin
            mv = 0;
         end
         if (open && win >= 0 && cmp && win == int'(rp)) begin
            // grant and completion on the same port cancel
         end else begin
            if (open && win >= 0) mc[win]++;
            if (cmp && mc[rp] > 0) mc[rp]--;
         end
      end
      #1;
      chk("arvalid", m_arvalid, mv);
      if (mv) chk("ar_payload",
                  {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}, mslot);
      chk("err", err, merr);
   endtask

   task automatic idle_inputs();
      v0 = 0; v1 = 0; m_arready = 1; m_rvalid = 0; m_rlast = 0; m_rid = 9'h000;
      rr0 = 1; rr1 = 1; m_rdata = 32'h0; m_rresp = 2'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   vec_t tbl[6];
   logic [45:0] cap;

   initial begin
      // contention table: both ports always requesting, downstream always ready
`ifdef SB_AXI_RD_ARB_FIXED_PRIO_EN
      tbl[0] = '{1, 1, 1, 1, 0}; tbl[1] = '{1, 1, 1, 1, 0}; tbl[2] = '{1, 1, 1, 1, 0};
      tbl[3] = '{1, 1, 1, 1, 0}; tbl[4] = '{1, 1, 1, 0, 1}; tbl[5] = '{1, 1, 1, 0, 1};
`else
      tbl[0] = '{1, 1, 1, 1, 0}; tbl[1] = '{1, 1, 1, 0, 1}; tbl[2] = '{1, 1, 1, 1, 0};
      tbl[3] = '{1, 1, 1, 0, 1}; tbl[4] = '{1, 1, 1, 1, 0}; tbl[5] = '{1, 1, 1, 0, 1};
`endif
      ar0 = '0; ar1 = '0;
      idle_inputs();
      mc[0] = 0; mc[1] = 0; mlg = 1; mv = 0; merr = 0; mslot = '0;
      rst = 1;
      step();
      chk("rst_arvalid", m_arvalid, 1'b0);
      chk("rst_payload", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}, 46'h0);
      chk("rst_err", err, 1'b0);
      v0 = 1; v1 = 1;
      step();
      chk("rst_no_ready", {smp_rdy0, smp_rdy1}, 2'b00);
      rst = 0;

      // contention table
      do_reset();
      ar0 = rand_ar(); ar1 = rand_ar();
      for (int i = 0; i < 6; i++) begin
         v0 = tbl[i].v0; v1 = tbl[i].v1; m_arready = tbl[i].mrdy;
         step();
         chk("tbl_rdy0", smp_rdy0, tbl[i].e0);
         chk("tbl_rdy1", smp_rdy1, tbl[i].e1);
      end

      // single port burst
      do_reset();
      ar0 = '{8'h12, 16'h0100, 8'd3, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0};
      v0 = 1;
      step();
      chk("sp_grant", smp_rdy0, 1'b1);
      chk("sp_arid", m_arid, 9'h012);
      chk("sp_araddr", m_araddr, 16'h0100);
      v0 = 0;
      for (int i = 0; i < 4; i++) begin
         m_rvalid = 1; m_rid = 9'h012; m_rlast = (i == 3); m_rdata = 32'hA000 + i;
         step();
         chk("sp_rvalid0", {s0_rvalid, s1_rvalid}, 2'b10);
         chk("sp_rid", s0_rid, 8'h12);
      end
      m_rvalid = 0; m_rlast = 0;
      step();
      chk("sp_noerr", err, 1'b0);

      // outstanding limit on port 0
      do_reset();
      ar0 = rand_ar();
      v0 = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("lim_rdy", smp_rdy0, (i < 4));
      end
      m_rvalid = 1; m_rid = 9'h000; m_rlast = 1; rr0 = 1;
      step();
      chk("lim_hold", smp_rdy0, 1'b0);
      m_rvalid = 0; m_rlast = 0;
      step();
      chk("lim_release", smp_rdy0, 1'b1);
      v0 = 0;

      // downstream backpressure with a full slot
      do_reset();
      ar0 = rand_ar(); ar1 = rand_ar();
      v0 = 1;
      step();
      cap = {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot};
      v1 = 1; m_arready = 0;
      for (int i = 0; i < 10; i++) begin
         ar0 = rand_ar(); ar1 = rand_ar();
         step();
         chk("bp_no_ready", {smp_rdy0, smp_rdy1}, 2'b00);
         chk("bp_stable", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}, cap);
      end
      m_arready = 1;
      step();
`ifdef SB_AXI_RD_ARB_FIXED_PRIO_EN
      chk("bp_winner", {smp_rdy0, smp_rdy1}, 2'b10);
`else
      chk("bp_winner", {smp_rdy0, smp_rdy1}, 2'b01);
`endif
      v0 = 0; v1 = 0;

      // R steering with port-1 backpressure
      do_reset();
      v0 = 1; step(); v0 = 0; v1 = 1; step(); v1 = 0;
      rr0 = 1; rr1 = 0;
      for (int i = 0; i < 6; i++) begin
         m_rvalid = 1; m_rid = (i % 2 == 0) ? 9'h105 : 9'h007; m_rdata = $urandom();
         step();
         chk("st_mrready", smp_mrready, (i % 2 == 1));
         chk("st_route", {s0_rvalid, s1_rvalid}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      rr1 = 1; m_rid = 9'h105;
      step();
      chk("st_release", smp_mrready, 1'b1);
      m_rvalid = 0;

      // error flag and reset mid-burst
      do_reset();
      m_rvalid = 1; m_rid = 9'h1AB; m_rlast = 1; rr1 = 1;
      step();
      chk("err_set", err, 1'b1);
      m_rvalid = 0; m_rlast = 0;
      step();
      chk("err_sticky", err, 1'b1);
      do_reset();
      v0 = 1; step(); v0 = 0;
      m_rvalid = 1; m_rid = 9'h000; m_rlast = 0;
      step();
      rst = 1;
      step();
      chk("mid_rst_err", err, 1'b0);
      chk("mid_rst_arvalid", m_arvalid, 1'b0);
      rst = 0;
      m_rlast = 1;
      step();
      chk("post_rst_err", err, 1'b1);

      // randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int p;
         v0 = ($urandom_range(0, 9) < 6);
         v1 = ($urandom_range(0, 9) < 6);
         ar0 = rand_ar(); ar1 = rand_ar();
         m_arready = ($urandom_range(0, 9) < 7);
         rr0 = ($urandom_range(0, 9) < 8);
         rr1 = ($urandom_range(0, 9) < 8);
         p = $urandom_range(0, 1);
         if (mc[p] == 0 && $urandom_range(0, 19) != 0) p = 1 - p;
         m_rvalid = ($urandom_range(0, 1) == 1);
         m_rid = {p[0], 8'($urandom())};
         m_rlast = ($urandom_range(0, 2) == 0);
         m_rdata = $urandom();
         m_rresp = 2'($urandom());
         if (n == 1500) rst = 1;
         step();
         rst = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sb_axi_rd_arb.md
# sb_axi_rd_arb

Two-to-one AXI4 read-channel arbiter that shares one downstream AXI read port (AR/R) between two upstream AXI masters. Sits between switchboard-driven AXI masters (or RTL masters) and a single AXI slave/interconnect port. It round-robins AR requests into a registered output slot, tags each request with a one-bit source ID extension, and routes R beats back by that tag. Per-port outstanding-transaction limits are enforced, and protocol errors are flagged.

## Interface
- DATA_WIDTH, 32, R data width
- ADDR_WIDTH, 16, AR address width
- ID_WIDTH, 8, upstream ID width; downstream ID is ID_WIDTH+1
- MAX_OUTSTANDING, 4, max accepted-but-incomplete bursts per upstream port (>=1)

- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- s{0,1}_axi_ar{id,addr,len,size,burst,lock,cache,prot}  input  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  upstream AR payload
- s{0,1}_axi_arvalid  input  1  upstream AR valid
- s{0,1}_axi_arready  output  1  upstream AR ready
- s{0,1}_axi_r{id,data,resp,last}  output  ID_WIDTH/DATA_WIDTH/2/1  upstream R payload
- s{0,1}_axi_rvalid  output  1  upstream R valid
- s{0,1}_axi_rready  input  1  upstream R ready
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot}  output  ID_WIDTH+1/ADDR_WIDTH/8/3/2/1/4/3  downstream AR payload
- m_axi_arvalid  output  1  downstream AR valid
- m_axi_arready  input  1  downstream AR ready
- m_axi_r{id,data,resp,last}  input  ID_WIDTH+1/DATA_WIDTH/2/1  downstream R payload
- m_axi_rvalid  input  1  downstream R valid
- m_axi_rready  output  1  downstream R ready
- err  output  1  sticky: R beat returned for a port with zero outstanding

## Operation
- AR slot: one register holding payload plus valid; slot is "open" when m_axi_arvalid=0 or m_axi_arready=1.
- Eligible port p: s{p}_axi_arvalid=1 and cnt[p] < MAX_OUTSTANDING.
- Grant, evaluated only when slot open: one eligible port -> that port; both eligible -> port != last_grant; none -> slot clears (if draining) and stays empty.
- s{p}_axi_arready = slot open & grant==p & !rst; never both high.
- On grant: slot loads payload, m_axi_arid = {p, s{p}_axi_arid}; last_grant <= p; cnt[p]++.
- R routing (combinational): p = m_axi_rid[ID_WIDTH]; s{p}_axi_rvalid = m_axi_rvalid; other port rvalid=0; m_axi_rready = s{p}_axi_rready; s{p}_axi_rid = m_axi_rid[ID_WIDTH-1:0]; data/resp/last broadcast to both.
- Burst completion (m_axi_rvalid & m_axi_rready & m_axi_rlast for port p): cnt[p]--.
- Simultaneous grant and completion on the same port: cnt unchanged.
- Completion while cnt[p]==0: cnt stays 0, err <= 1 (cleared only by rst).
- Counter width $clog2(MAX_OUTSTANDING+1); never exceeds MAX_OUTSTANDING, never wraps.

## Timing
- Reset values: m_axi_arvalid=0, m_axi_ar* payload=0, last_grant=1 (port 0 wins first tie), cnt[0]=cnt[1]=0, err=0; s*_axi_arready=0 during rst.
- AR latency: upstream handshake in cycle N -> m_axi_arvalid=1 in N+1; full throughput (one AR per cycle) when m_axi_arready held high.
- Payload stable while m_axi_arvalid=1 and m_axi_arready=0 (AXI rule); no retraction.
- R path: zero-cycle combinational, no buffering; backpressure passes straight through.
- Reset mid-operation: slot and counters dropped immediately; in-flight downstream bursts are not tracked afterward (their R beats set err).

## Configuration
- SB_AXI_RD_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins when both eligible; last_grant unused.
- Undefined (default): round-robin as described above.

## Test plan
- Single port: s0 issues AR id=0x12 addr=0x100 len=3 -> m_axi_arid=0x012 next cycle; 4 R beats id=0x012 delivered on s0 with rid=0x12, cnt[0] 1->0 at rlast.
- Contention: s0,s1 both valid continuously, arready=1 -> grants alternate 0,1,0,1 starting with 0 (with FIXED_PRIO_EN: 0,0,0,...).
- Outstanding limit: MAX_OUTSTANDING=4, s0 issues 5 ARs, no R -> 5th held (s0_axi_arready=0) until one rlast for s0, then accepted next open slot.
- Backpressure: m_axi_arready=0 for 10 cycles with slot full -> payload stable, both s*_axi_arready=0; s1 pending wins when ready returns if last_grant=0.
- R steering: interleaved R beats id=0x1_05 and 0x0_07 with s1_axi_rready=0 -> m_axi_rready=0 on port-1 beats, port-0 beats pass; no beat lost or duplicated.
- Error: R beat with rlast for port 1 while cnt[1]=0 -> err=1 next cycle, cnt[1]=0; assert rst mid-burst -> err=0, m_axi_arvalid=0.
